tohost_tx_sched: RTL and testbench

Tohost console scheduler for the ultrasmall RV32I system. It snoops core data-memory writes, decodes tohost commands (print character, power off), buffers characters in a FIFO, and sequences them one at a time into the UART transmitter. It also produces a sticky power-off flag and a drain-complete flag for the top level. It sits between the core's D-port and the `UartTx` instance.

---
 rtl/usmall_pkg.sv | 20 ++
 rtl/tohost_fifo.sv | 66 ++++++
 rtl/tohost_tx_sched.sv | 138 +++++++++++++
 tb/tb_tohost_tx_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usmall_pkg.sv
// Shared definitions for the ultrasmall RV32I system: tohost command codes,
// the default tohost register address and the console scheduler FSM states.
package usmall_pkg;

    // Command field, write-data bits [17:16] of a tohost store.
    localparam logic [1:0]  TOHOST_CMD_PRINT    = 2'd1;
    localparam logic [1:0]  TOHOST_CMD_POWEROFF = 2'd2;

    // Byte address of the tohost register.
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h4000_8000;

    // Console scheduler states.
    typedef enum logic [1:0] {
        TXS_IDLE  = 2'd0,
        TXS_ISSUE = 2'd1,
        TXS_GUARD = 2'd2,
        TXS_BUSY  = 2'd3
    } txs_state_t;

endpackage

// File: rtl/tohost_fifo.sv
// Character FIFO for the tohost console: circular buffer tracked by a head
// pointer plus an occupancy count. Pushes into a full buffer are dropped,
// even when a pop happens on the same edge.
module tohost_fifo #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] tail;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    // DEPTH is a power of two, so the AW-bit sum wraps modulo DEPTH.
    assign tail    = head_q + count_q[AW-1:0];
    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;

    // Next head and occupancy; simultaneous push and pop cancel in the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        head_d  = head_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        if (pop_ok) begin
            head_d = head_q + AW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Character storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
        if (push_ok) begin
            mem_q[tail] <= wdata_i;
        end
    end

endmodule

// File: rtl/tohost_tx_sched.sv
// Tohost console scheduler: snoops core stores to the tohost register,
// decodes print/power-off commands through a two-stage pipeline, queues
// characters and feeds them one per frame to the UART transmitter.
module tohost_tx_sched
    import usmall_pkg::*;
#(
    parameter int          QUEUE_SIZE  = 64,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
    localparam int         CW          = $clog2(QUEUE_SIZE) + 1
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [31:0]   D_ADDR,
    input  logic [3:0]    D_WE,
    input  logic [31:0]   WD_DATA,
    input  logic          TX_READY,
    output logic [7:0]    TX_DATA,
    output logic          TX_WE,
    output logic          POWEROFF,
    output logic          DRAINED,
    output logic          OVERFLOW,
    output logic [CW-1:0] QCOUNT
);

    // Stage 1 keeps only the fields the decoder looks at: {cmd, ch}.
    logic       hit_q;
    logic [9:0] data_q;
    logic [1:0] cmd_q;
    logic [7:0] ch_q;

    logic       poweroff_q;
    logic       overflow_q;

    txs_state_t state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_we_q, tx_we_d;
    logic       pop;

    logic          push;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Upper byte enables and unused data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{D_WE[3:1], WD_DATA[31:18], WD_DATA[15:8]};

    assign push = (cmd_q == TOHOST_CMD_PRINT);

    // Two-stage snoop pipeline on the core D-port.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            hit_q  <= 1'b0;
            data_q <= '0;
            cmd_q  <= '0;
            ch_q   <= '0;
        end else begin
            hit_q  <= (D_ADDR == TOHOST_ADDR) & D_WE[0];
            data_q <= {WD_DATA[17:16], WD_DATA[7:0]};
            cmd_q  <= hit_q ? data_q[9:8] : 2'd0;
            ch_q   <= data_q[7:0];
        end
    end

    // Sticky power-off and character-dropped flags.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            poweroff_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            poweroff_q <= poweroff_q | (cmd_q == TOHOST_CMD_POWEROFF);
            overflow_q <= overflow_q | (push & fifo_full);
        end
    end

    tohost_fifo #(
        .DEPTH (QUEUE_SIZE)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_X),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ch_q),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Transmit sequencer: issue one strobe, wait out the UART's READY
    // deassert latency in GUARD, then wait for the frame to finish.
    always_comb begin
        state_d   = state_q;
        tx_data_d = 8'h00;
        tx_we_d   = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            TXS_IDLE: begin
                if (!fifo_empty && TX_READY) begin
                    state_d   = TXS_ISSUE;
                    tx_data_d = fifo_rdata;
                    tx_we_d   = 1'b1;
                    pop       = 1'b1;
                end
            end
            TXS_ISSUE: state_d = TXS_GUARD;
            TXS_GUARD: state_d = TXS_BUSY;
            TXS_BUSY: begin
                if (TX_READY) begin
                    state_d = TXS_IDLE;
                end
            end
            default: state_d = TXS_IDLE;
        endcase
    end

    // Sequencer state and registered UART outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= TXS_IDLE;
            tx_data_q <= 8'h00;
            tx_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_we_q   <= tx_we_d;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_WE    = tx_we_q;
    assign POWEROFF = poweroff_q;
    assign OVERFLOW = overflow_q;
    assign QCOUNT   = fifo_count;
    assign DRAINED  = poweroff_q & fifo_empty & (state_q == TXS_IDLE);

endmodule

// File: tb/tb_tohost_tx_sched.sv
// Directed bench for tohost_tx_sched with a four-entry queue and a small
// UART model whose READY drops one cycle after the strobe is seen.
module tb_tohost_tx_sched;

    localparam logic [31:0] TOHOST = 32'h4000_8000;
    localparam int          FRAME  = 4;

    logic        clk;
    logic        rst_x;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] wd_data;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        poweroff;
    logic        drained;
    logic        overflow;
    logic [2:0]  qcount;

    logic uart_rdy = 1'b1;
    logic hold     = 1'b0;
    wire  tx_ready = uart_rdy & ~hold;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [7:0] rx [$];
    int cyc        = 0;
    int last_we    = 0;
    int n_strobes  = 0;
    int min_gap    = 1000;
    int nz_idle    = 0;
    int pend       = 0;
    int busy       = 0;

    tohost_tx_sched #(
        .QUEUE_SIZE  (4),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .CLK      (clk),
        .RST_X    (rst_x),
        .D_ADDR   (d_addr),
        .D_WE     (d_we),
        .WD_DATA  (wd_data),
        .TX_READY (tx_ready),
        .TX_DATA  (tx_data),
        .TX_WE    (tx_we),
        .POWEROFF (poweroff),
        .DRAINED  (drained),
        .OVERFLOW (overflow),
        .QCOUNT   (qcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: READY stays high through the cycle after the strobe, then
    // drops for FRAME cycles.
    always @(negedge clk or negedge rst_x) begin
        if (!rst_x) begin
            pend     = 0;
            busy     = 0;
            uart_rdy = 1'b1;
        end else begin
            if (pend == 1) begin
                pend = 0;
                busy = FRAME;
            end else if (pend > 0) begin
                pend--;
            end else if (busy > 0) begin
                busy--;
            end
            if (tx_we) pend = 2;
            uart_rdy = (busy == 0);
        end
    end

    // Monitor: collect sent characters, strobe spacing and idle data.
    always @(negedge clk) begin
        cyc++;
        if (tx_we) begin
            rx.push_back(tx_data);
            if (n_strobes > 0 && (cyc - last_we) < min_gap) min_gap = cyc - last_we;
            last_we = cyc;
            n_strobes++;
        end else if (tx_data != 8'h00) begin
            nz_idle++;
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        d_addr  = a;
        d_we    = we;
        wd_data = d;
        @(negedge clk);
        d_addr  = '0;
        d_we    = '0;
        wd_data = '0;
    endtask

    // One print write per cycle; returns at the negedge after the last sample.
    task automatic burst_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            d_addr  = TOHOST;
            d_we    = 4'h1;
            wd_data = {14'b0, 2'd1, 8'h00, s[i]};
        end
        @(negedge clk);
        d_addr  = '0;
        d_we    = '0;
        wd_data = '0;
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 400 && q < 4; i++) begin
            @(negedge clk);
            if (qcount == 0 && !tx_we && tx_ready) q++;
            else q = 0;
        end
        check(tag, 32'(q >= 4), 32'd1);
    endtask

    task automatic check_rx(input string tag, input string exp);
        check({tag, "_len"}, 32'(rx.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            check($sformatf("%s_ch%0d", tag, i), 32'(rx[i]), 32'(exp[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_x = 1'b0;
        repeat (2) @(negedge clk);
        rst_x = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_since;
        int rx_before;
        bit saw;

        rst_x = 1'b1; d_addr = '0; d_we = '0; wd_data = '0; hold = 1'b0;
        #1 rst_x = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_tx_we",    32'(tx_we),    32'd0);
        check("rst_poweroff", 32'(poweroff), 32'd0);
        check("rst_drained",  32'(drained),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_qcount",   32'(qcount),   32'd0);
        rst_x = 1'b1;

        // Single print, idle UART: strobe in the cycle after E+3.
        bus_wr(TOHOST, 4'h1, 32'h0001_0041);
        check("t1_we_e0", 32'(tx_we), 32'd0);
        @(negedge clk);
        check("t1_we_e1", 32'(tx_we), 32'd0);
        @(negedge clk);
        check("t1_qcount_e2", 32'(qcount), 32'd1);
        check("t1_we_e2", 32'(tx_we), 32'd0);
        @(negedge clk);
        check("t1_we_e3", 32'(tx_we), 32'd1);
        check("t1_data_e3", 32'(tx_data), 32'h41);
        check("t1_qcount_e3", 32'(qcount), 32'd0);
        @(negedge clk);
        check("t1_we_e4", 32'(tx_we), 32'd0);
        check("t1_data_e4", 32'(tx_data), 32'd0);
        wait_quiet("t1_settle");
        check_rx("t1_rx", "A");
        rx.delete();

        // Non-matching traffic and no-op commands.
        bus_wr(32'h4000_8004, 4'h1, 32'h0001_0058);
        bus_wr(TOHOST,        4'h2, 32'h0001_0058);
        bus_wr(TOHOST,        4'h1, 32'h0000_0058);
        bus_wr(TOHOST,        4'h1, 32'h0003_0058);
        repeat (6) @(negedge clk);
        check("t2_qcount",   32'(qcount),    32'd0);
        check("t2_no_tx",    32'(rx.size()), 32'd0);
        check("t2_poweroff", 32'(poweroff),  32'd0);
        check("t2_overflow", 32'(overflow),  32'd0);

        // Overflow with the UART held busy.
        hold = 1'b1;
        burst_str("abcdef");
        repeat (2) @(negedge clk);
        check("t3_qcount", 32'(qcount),   32'd4);
        check("t3_overflow", 32'(overflow), 32'd1);
        hold = 1'b0;
        wait_quiet("t3_settle");
        check_rx("t3_rx", "abcd");
        rx.delete();

        // Push into a full queue on the same edge as a pop.
        do_reset();
        check("t4_overflow_cleared", 32'(overflow), 32'd0);
        hold = 1'b1;
        burst_str("pqrs");
        repeat (2) @(negedge clk);
        check("t4_qcount_full", 32'(qcount), 32'd4);
        check("t4_overflow_pre", 32'(overflow), 32'd0);
        bus_wr(TOHOST, 4'h1, 32'h0001_0074);
        @(negedge clk);
        hold = 1'b0;
        @(negedge clk);
        check("t4_qcount_pushpop", 32'(qcount), 32'd3);
        check("t4_overflow_post", 32'(overflow), 32'd1);
        check("t4_we", 32'(tx_we), 32'd1);
        check("t4_data", 32'(tx_data), 32'h70);
        wait_quiet("t4_settle");
        foreach (rx[i]) begin end
        for (int r = 0; r < 3; r++) begin
            string grp;
            grp = (r == 0) ? "ABCD" : (r == 1) ? "EFGH" : "IJKL";
            hold = 1'b1;
            burst_str(grp);
            repeat (2) @(negedge clk);
            check($sformatf("t4_wrap%0d_qcount", r), 32'(qcount), 32'd4);
            hold = 1'b0;
            wait_quiet($sformatf("t4_wrap%0d_settle", r));
        end
        check_rx("t4_rx", "pqrsABCDEFGHIJKL");
        rx.delete();

        // Power-off while characters are still queued.
        burst_str("hi");
        bus_wr(TOHOST, 4'h1, 32'h0002_0000);
        check("t5_poweroff_e0", 32'(poweroff), 32'd0);
        @(negedge clk);
        check("t5_poweroff_e1", 32'(poweroff), 32'd0);
        @(negedge clk);
        check("t5_poweroff_e2", 32'(poweroff), 32'd1);
        check("t5_drained_e2", 32'(drained), 32'd0);
        n_since = 0;
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_we) n_since = 0;
            else n_since++;
            if (drained) begin
                saw = 1'b1;
                break;
            end
        end
        check("t5_drained_seen", 32'(saw), 32'd1);
        check("t5_drained_delay", 32'(n_since), 32'd7);
        check("t5_qcount", 32'(qcount), 32'd0);
        check_rx("t5_rx", "hi");
        rx.delete();

        // Reset asserted while BUSY with three characters queued.
        hold = 1'b1;
        burst_str("wxyz");
        repeat (2) @(negedge clk);
        check("t6_qcount_full", 32'(qcount), 32'd4);
        hold = 1'b0;
        @(negedge clk);
        check("t6_we", 32'(tx_we), 32'd1);
        check("t6_data", 32'(tx_data), 32'h77);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_qcount_busy", 32'(qcount), 32'd3);
        #2 rst_x = 1'b0;
        #1;
        check("t6_rst_tx_data",  32'(tx_data),  32'd0);
        check("t6_rst_tx_we",    32'(tx_we),    32'd0);
        check("t6_rst_poweroff", 32'(poweroff), 32'd0);
        check("t6_rst_drained",  32'(drained),  32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_qcount",   32'(qcount),   32'd0);
        rx_before = rx.size();
        @(negedge clk);
        rst_x = 1'b1;
        hold  = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_tx_after", 32'(rx.size()), 32'(rx_before));
        check("t6_qcount_after", 32'(qcount), 32'd0);

        check("min_we_gap", 32'(min_gap >= 4), 32'd1);
        check("tx_data_idle_zero", 32'(nz_idle), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
